// File: rtl/router_output_arbiter_if.sv
// Bundle between the router input ports, the output channel and the output arbiter.
interface router_output_arbiter_if #(
  parameter int NUM_PORTS  = 5,
  parameter int DATA_WIDTH = 64
);
  logic                            polarity;
  logic                            blocked;
  logic [NUM_PORTS-1:0]            req;
  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in;
  logic [NUM_PORTS-1:0]            grant;
  logic                            out_valid;
  logic [DATA_WIDTH-1:0]           data_out;

  modport master (
    output polarity, blocked, req, data_in,
    input  grant, out_valid, data_out
  );

  modport slave (
    input  polarity, blocked, req, data_in,
    output grant, out_valid, data_out
  );
endinterface

// File: rtl/router_output_arbiter.sv
// Round-robin output arbiter for one mesh-router output channel, with a separate
// fairness pointer per virtual channel and a one-cycle registered grant.
module router_output_arbiter #(
  parameter int NUM_PORTS  = 5,
  parameter int DATA_WIDTH = 64
) (
  input logic                    clk,
  input logic                    reset,
  router_output_arbiter_if.slave bus
);
  localparam int              PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PW-1:0]   LAST = PW'(NUM_PORTS - 1);

  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] flit;
  logic [NUM_PORTS-1:0]                 elig;
  logic [NUM_PORTS-1:0]                 grant_q;
  logic                                 out_valid_q;
  logic [DATA_WIDTH-1:0]                data_q;
  logic [PW-1:0]                        ptr_vc1, ptr_vc0, ptr;
  logic [PW-1:0]                        idx, win, win_nxt;
  logic                                 found, take;

  // A port granted last cycle is masked so a still-held request is not regranted.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign flit[p] = bus.data_in[p*DATA_WIDTH +: DATA_WIDTH];
    assign elig[p] = bus.req[p] & (flit[p][DATA_WIDTH-1] == bus.polarity) & ~grant_q[p];
  end

  assign ptr = bus.polarity ? ptr_vc1 : ptr_vc0;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = PW'((int'(ptr) + k) % NUM_PORTS);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign take    = found & ~bus.blocked;
  assign win_nxt = (win == LAST) ? '0 : win + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      ptr_vc1     <= '0;
      ptr_vc0     <= '0;
    end else begin
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      if (take) begin
        grant_q[win] <= 1'b1;
        out_valid_q  <= 1'b1;
        data_q       <= flit[win];
        if (bus.polarity) ptr_vc1 <= win_nxt;
        else              ptr_vc0 <= win_nxt;
      end
    end
  end

  assign bus.grant     = grant_q;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_q;
endmodule
